// File: rtl/sc_io_display.sv
// Memory-mapped seven-segment output stage: three two-digit decimal channels converted serially
// by a double-dabble engine. Define SC_IO_DISPLAY_LZ_BLANK_EN to blank a leading-zero tens digit.
module sc_io_display #(
  parameter logic [31:0] CH0_ADDR = 32'hffffff00,
  parameter logic [31:0] CH1_ADDR = 32'hffffff10,
  parameter logic [31:0] CH2_ADDR = 32'hffffff20
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  output logic        busy,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_DASH  = 7'b011_1111;

  logic [1:0] r_state;
  logic [2:0] r_vld;
  logic [7:0] r_val [3];
  logic [6:0] r_bin;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic [2:0] r_cnt;
  logic [1:0] r_ch;
  logic       r_big;
  logic [6:0] r_hex [6];

  logic [2:0]  w_hit;
  logic        w_accept;
  logic [1:0]  w_store_ch;
  logic [7:0]  w_val;
  logic        w_any_pend;
  logic [1:0]  w_pick;
  logic        w_start;
  logic        w_direct;
  logic [1:0]  w_load_ch;
  logic [7:0]  w_load_val;
  logic [3:0]  w_tens_adj;
  logic [3:0]  w_ones_adj;
  logic [14:0] w_cat;
  logic [6:0]  w_seg_tens;
  logic [6:0]  w_seg_ones;
  logic        w_unused_datain;

  assign w_unused_datain = ^datain[31:8];
  assign w_val = datain[7:0];

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b100_0000;
      4'd1:    f_seg = 7'b111_1001;
      4'd2:    f_seg = 7'b010_0100;
      4'd3:    f_seg = 7'b011_0000;
      4'd4:    f_seg = 7'b001_1001;
      4'd5:    f_seg = 7'b001_0010;
      4'd6:    f_seg = 7'b000_0010;
      4'd7:    f_seg = 7'b111_1000;
      4'd8:    f_seg = 7'b000_0000;
      4'd9:    f_seg = 7'b001_0000;
      default: f_seg = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    w_hit      = {we && (addr == CH2_ADDR), we && (addr == CH1_ADDR), we && (addr == CH0_ADDR)};
    w_accept   = |w_hit;
    w_store_ch = w_hit[2] ? 2'd2 : (w_hit[1] ? 2'd1 : 2'd0);
    w_any_pend = |r_vld;
    w_pick     = r_vld[0] ? 2'd0 : (r_vld[1] ? 2'd1 : 2'd2);
    w_start    = (r_state == IDLE) && (w_any_pend || w_accept);
    w_direct   = (r_state == IDLE) && !w_any_pend && w_accept;
    w_load_ch  = w_any_pend ? w_pick : w_store_ch;
    w_load_val = w_any_pend ? r_val[w_pick] : w_val;
  end

  // One double-dabble step: adjust BCD nibbles, then shift the whole register left.
  always_comb begin
    w_tens_adj = (r_tens >= 4'd5) ? r_tens + 4'd3 : r_tens;
    w_ones_adj = (r_ones >= 4'd5) ? r_ones + 4'd3 : r_ones;
    w_cat      = {w_tens_adj, w_ones_adj, r_bin};
  end

  always_comb begin
    w_seg_ones = f_seg(r_ones);
    w_seg_tens = f_seg(r_tens);
`ifdef SC_IO_DISPLAY_LZ_BLANK_EN
    if (r_tens == 4'd0) w_seg_tens = SEG_BLANK;
`endif
    if (r_big) begin
      w_seg_ones = SEG_DASH;
      w_seg_tens = SEG_DASH;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_vld <= 3'b000;
      for (int i = 0; i < 3; i++) r_val[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 3; i++) begin
        // A store on the same edge as a pick of that slot wins: the slot refills.
        if (w_hit[i] && !w_direct) begin
          r_vld[i] <= 1'b1;
          r_val[i] <= w_val;
        end else if ((r_state == IDLE) && w_any_pend && (w_pick == 2'(i))) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_bin   <= 7'd0;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
      r_cnt   <= 3'd0;
      r_ch    <= 2'd0;
      r_big   <= 1'b0;
      for (int i = 0; i < 6; i++) r_hex[i] <= SEG_BLANK;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_bin   <= w_load_val[6:0];
            r_big   <= (w_load_val >= 8'd100);
            r_ch    <= w_load_ch;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_cnt   <= 3'd0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_tens <= w_cat[13:10];
          r_ones <= w_cat[9:6];
          r_bin  <= {w_cat[5:0], 1'b0};
          r_cnt  <= r_cnt + 3'd1;
          if (r_cnt == 3'd6) r_state <= UPDATE;
        end
        UPDATE: begin
          r_hex[{r_ch, 1'b1}] <= w_seg_tens;
          r_hex[{r_ch, 1'b0}] <= w_seg_ones;
          r_state             <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE) || (|r_vld);
  assign hex0 = r_hex[0];
  assign hex1 = r_hex[1];
  assign hex2 = r_hex[2];
  assign hex3 = r_hex[3];
  assign hex4 = r_hex[4];
  assign hex5 = r_hex[5];

endmodule
